// File: rtl/ct_pt_addsub_stream_if.sv
// ct_pt_addsub_stream_if: beat stream in/out bundle
// master drives beats in and accepts results; slave is the engine
interface ct_pt_addsub_stream_if #(
  parameter int LANES = 4,
  parameter int W     = 16,
  parameter int IW    = 1
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_mode;
  logic [LANES-1:0][W-1:0] in_a;
  logic [LANES-1:0][W-1:0] in_b;
  logic [LANES-1:0][W-1:0] in_gamma;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0][W-1:0] out_a;
  logic [LANES-1:0][W-1:0] out_b;
  logic [IW-1:0]           out_idx;
  logic                    out_last;
  logic [LANES-1:0]        out_err;

  modport master (
    output in_valid, in_mode, in_a, in_b, in_gamma,
    output out_ready,
    input  in_ready,
    input  out_valid, out_a, out_b, out_idx,
    input  out_last, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_a, in_b, in_gamma,
    input  out_ready,
    output in_ready,
    output out_valid, out_a, out_b, out_idx,
    output out_last, out_err
  );
endinterface

// File: rtl/ct_pt_addsub_stream.sv
// ct_pt_addsub_stream: two-stage B' = B +/- delta*gamma mod Q
// over LANES-wide beats, A passed through, valid/ready stalls
module ct_pt_addsub_stream #(
  parameter int N      = 8,
  parameter int W      = 16,
  parameter int LANES  = 4,
  parameter int QP     = 65521,
  parameter int DELTAP = 256,
  parameter int TP     = QP / DELTAP
) (
  input logic clk,
  input logic rst_n,
  ct_pt_addsub_stream_if.slave io
);
  localparam int BEATS = N / LANES;
  localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [W:0]   QX = (W+1)'(QP);
  localparam logic [W-1:0] QW = W'(QP);
  localparam logic [W-1:0] DW = W'(DELTAP);
  localparam logic [W-1:0] TW = W'(TP);
  localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

  typedef logic [LANES-1:0][W-1:0] vec_t;

  typedef struct packed {
    vec_t             a;
    vec_t             b;
    vec_t             p;
    logic [LANES-1:0] err;
    logic             mode;
    logic [IW-1:0]    idx;
    logic             last;
  } s1_t;

  logic          s1_valid;
  logic          s1_en;
  logic          s2_en;
  logic          acc;
  logic          first;
  logic          eff_mode;
  logic          frame_mode;
  logic [IW-1:0] cnt;
  s1_t           s1_d;
  s1_t           s1_q;
  vec_t          res_b;

  assign s2_en       = !io.out_valid || io.out_ready;
  assign s1_en       = !s1_valid || s2_en;
  assign io.in_ready = s1_en;
  assign acc         = io.in_valid && s1_en;
  assign first       = (cnt == '0);
  assign eff_mode    = first ? io.in_mode : frame_mode;

  // out-of-range gamma contributes zero, so B rides through untouched
  always_comb begin
    s1_d      = '0;
    s1_d.a    = io.in_a;
    s1_d.b    = io.in_b;
    s1_d.mode = eff_mode;
    s1_d.idx  = cnt;
    s1_d.last = (cnt == LAST_IDX);
    for (int l = 0; l < LANES; l++) begin
      s1_d.err[l] = (io.in_gamma[l] >= TW);
      s1_d.p[l]   = s1_d.err[l] ? '0 : DW * io.in_gamma[l];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [W:0]   sum;
    logic [W-1:0] add_r;
    logic [W-1:0] sub_r;

    assign sum   = {1'b0, s1_q.b[l]} + {1'b0, s1_q.p[l]};
    assign add_r = (sum >= QX) ? W'(sum - QX) : sum[W-1:0];
    // wrap in W bits is harmless: the true result is below Q
    assign sub_r = (s1_q.b[l] >= s1_q.p[l])
                 ? s1_q.b[l] - s1_q.p[l]
                 : s1_q.b[l] + QW - s1_q.p[l];
    assign res_b[l] = s1_q.err[l] ? s1_q.b[l]
                    : (s1_q.mode ? sub_r : add_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_q       <= '0;
      cnt        <= '0;
      frame_mode <= 1'b0;
    end else begin
      if (s1_en) s1_valid <= io.in_valid;
      if (acc) begin
        s1_q <= s1_d;
        cnt  <= (cnt == LAST_IDX) ? '0 : cnt + IW'(1);
        if (first) frame_mode <= io.in_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.out_a     <= '0;
      io.out_b     <= '0;
      io.out_idx   <= '0;
      io.out_last  <= 1'b0;
      io.out_err   <= '0;
    end else if (s2_en) begin
      io.out_valid <= s1_valid;
      if (s1_valid) begin
        io.out_a    <= s1_q.a;
        io.out_b    <= res_b;
        io.out_idx  <= s1_q.idx;
        io.out_last <= s1_q.last;
        io.out_err  <= s1_q.err;
      end
    end
  end
endmodule

// File: doc/ct_pt_addsub_stream.md
# ct_pt_addsub_stream

Streaming, pipelined ciphertext–plaintext add/subtract engine for the RLWE datapath. It applies `B' = B ± Δ·γ mod Q` to a ciphertext arriving as a stream of LANES-wide coefficient beats and passes `A` through unchanged. It generalises the combinational whole-vector ct+pt adder in three ways: a configurable lane count, a per-frame add/sub mode, and valid/ready backpressure. It sits between the coefficient-memory readout and the ciphertext writeback stage.

## Interface

Parameters:
- `N`, `N_SLOTS_L`: coefficients per polynomial; must be divisible by LANES.
- `W`, `W_BITS_L`: coefficient width.
- `LANES`, 4: coefficients per beat.
- `QP`, `Q_MOD_L`: ciphertext modulus Q.
- `DELTAP`, `DELTA_L`: scaling factor Δ.
- `TP`, `Q_MOD_L / DELTA_L`: plaintext bound T. Requires `Δ·(T-1) < Q`.
- Derived: `BEATS = N/LANES`, `IW = max(1, $clog2(BEATS))`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: engine accepts a beat.
- `in_mode` in 1: 0 = add, 1 = subtract. Sampled on frame's first beat only.
- `in_a` in LANES×W: ciphertext A coefficients.
- `in_b` in LANES×W: ciphertext B coefficients, each < Q.
- `in_gamma` in LANES×W: plaintext coefficients.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts.
- `out_a` out LANES×W: A pass-through.
- `out_b` out LANES×W: result B'.
- `out_idx` out IW: beat index within frame.
- `out_last` out 1: `out_idx == BEATS-1`.
- `out_err` out LANES: per-lane flag, set when γ ≥ T.

## Operation

- Input beat accepted when `in_valid && in_ready`. Output transferred when `out_valid && out_ready`.
- Beat counter `cnt` (IW bits) increments on each accepted beat. It wraps from BEATS-1 to 0. With BEATS=1 every beat is first and last.
- When `cnt == 0` at acceptance, `in_mode` is latched into `frame_mode`. Later beats of the frame use `frame_mode` and ignore `in_mode`.
- Stage 1 registers, per lane:
  - `P = Δ·γ` (2W-bit product, truncated to W bits once validated < Q).
  - A and B.
  - `err = (γ ≥ T)`.
  - Effective mode, `cnt`, and last flag.
- Stage 2 reduces, per lane:
  - err: `B' = B` (Δγ treated as 0); `out_err[lane] = 1`.
  - add: `s = B + P` in W+1 bits. `B' = s - Q` if `s ≥ Q`, else `s`.
  - sub: `B' = B - P` if `B ≥ P`, else `B + Q - P`, computed in W+1 bits.
- All comparisons are unsigned. No result is ever ≥ Q given the input preconditions. Behaviour for `B ≥ Q` is undefined.
- Beat order is preserved, with no drops and no duplicates.

## Timing

- Two-register pipeline; latency 2 cycles from acceptance to `out_valid` when unstalled.
- Throughput is one beat per cycle when `out_ready` is held high.
- Stall rules:
  - `s2_en = !s2_valid || out_ready`.
  - `s1_en = !s1_valid || s2_en`.
  - `in_ready = s1_en`, combinational.
- While stalled, the engine holds 2 beats. Outputs stay stable while `out_valid && !out_ready`.
- Simultaneous accept and transfer in the same cycle is allowed. The pipeline advances without a bubble.
- Reset, asynchronous, any time including mid-frame:
  - Pipeline valids, `cnt`, and `frame_mode` clear to 0.
  - `out_valid`, `out_a`, `out_b`, `out_idx`, `out_last`, and `out_err` read 0.
  - Partially accepted frames are discarded. The next accepted beat is beat 0 of a new frame.
- `in_ready` reads 1 whenever the pipeline is empty, including during reset. Beats are not accepted while `rst_n` is low.

## Test plan

Bench configuration: W=16, Q=65521, Δ=256, T=255, N=8, LANES=4 (BEATS=2).

- Add, mode=0: B=65000, γ=3 → P=768, `out_b`=247 after 2 cycles. B=10, γ=0 → 10.
- Subtract, mode=1: B=100, γ=1 → 65365. B=1000, γ=2 → 488. `out_a` equals `in_a` on every lane.
- Range: γ=254 → B+65024 reduced, `out_err`=0. γ=255 → `out_err` lane set, `out_b`=B unchanged.
- Backpressure: continuous input, `out_ready` low for 5 cycles. `in_ready` drops after exactly 2 beats are held. Releasing gives the in-order sequence with no loss, and `out_b` is stable while stalled.
- Framing: `in_mode` toggled on beat 1 is ignored. `out_idx` is 0 then 1, and `out_last` is high on beat 1 only. The next frame relatches mode.
- Mid-frame reset: assert `rst_n`=0 after beat 0 is accepted. `out_valid` goes 0 immediately. After release, the first beat reports `out_idx`=0 and uses its own `in_mode`.
